// File: rtl/bp_be_prefetch_scheduler.sv
// Prefetch scheduler: allocates striding loads to idle stride generators (dedup by PC),
// round-robins their requests onto one dispatch port under credit and dcache-miss throttling.

module bp_be_prefetch_stream_entry
 #(parameter int vaddr_width_p = 39)
  (input  logic                     clk_i
  ,input  logic                     reset_i
  ,input  logic                     flush_i
  ,input  logic                     idle_i
  ,input  logic                     grant_i
  ,input  logic [vaddr_width_p-1:0] pc_i
  ,output logic                     hit_o
  ,output logic                     free_o
  );

  logic                     valid_q, valid_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (flush_i)      valid_d = 1'b0;
    else if (grant_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
    end
    // generator back in its wait state means the stream it was running has ended
    else if (idle_i)  valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end

  assign hit_o  = valid_q & (pc_q == pc_i);
  assign free_o = ~valid_q & idle_i;

endmodule

module bp_be_prefetch_scheduler
 #(parameter int vaddr_width_p      = 39
  ,parameter int num_streams_p      = 4
  ,parameter int credits_p          = 2
  ,localparam int stream_id_width_lp = (num_streams_p > 1) ? $clog2(num_streams_p) : 1
  )
  (input  logic                                    clk_i
  ,input  logic                                    reset_i
  ,input  logic                                    flush_i
  ,input  logic                                    alloc_v_i
  ,input  logic [vaddr_width_p-1:0]                alloc_pc_i
  ,output logic                                    alloc_ready_and_o
  ,output logic [num_streams_p-1:0]                alloc_grant_o
  ,input  logic [num_streams_p-1:0]                gen_idle_i
  ,input  logic [num_streams_p-1:0]                gen_v_i
  ,input  logic [num_streams_p*vaddr_width_p-1:0]  gen_eff_addr_i
  ,output logic [num_streams_p-1:0]                gen_yumi_o
  ,output logic                                    v_o
  ,output logic [vaddr_width_p-1:0]                eff_addr_o
  ,output logic [stream_id_width_lp-1:0]           stream_id_o
  ,input  logic                                    yumi_i
  ,input  logic                                    pfetch_commit_v_i
  ,input  logic                                    dcache_processing_miss_i
  );

  localparam int cw_lp = $clog2(credits_p+1);
  localparam logic [num_streams_p-1:0] one_lp = num_streams_p'(1);

  typedef enum logic {e_run, e_drain} state_e;

  state_e                        state_q, state_d;
  logic [cw_lp-1:0]              credits_q, credits_d;
  logic [stream_id_width_lp-1:0] rr_ptr_q, rr_ptr_d;

  logic [num_streams_p-1:0]      hit, free;
  logic                          hit_any, free_any, run_ok, can_issue, issue;
  logic [stream_id_width_lp-1:0] free_id, grant_id;

  for (genvar s = 0; s < num_streams_p; s++) begin : g_entry
    bp_be_prefetch_stream_entry #(.vaddr_width_p(vaddr_width_p)) entry
      (.clk_i   (clk_i)
      ,.reset_i (reset_i)
      ,.flush_i (flush_i)
      ,.idle_i  (gen_idle_i[s])
      ,.grant_i (alloc_grant_o[s])
      ,.pc_i    (alloc_pc_i)
      ,.hit_o   (hit[s])
      ,.free_o  (free[s])
      );
  end

  always_comb begin
    free_id = '0;
    for (int s = num_streams_p-1; s >= 0; s--)
      if (free[s]) free_id = stream_id_width_lp'(s);
  end

  always_comb begin
    int idx;
    logic found;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < num_streams_p; i++) begin
      idx = (int'(rr_ptr_q) + i) % num_streams_p;
      if (!found && gen_v_i[idx]) begin
        found    = 1'b1;
        grant_id = stream_id_width_lp'(idx);
      end
    end
  end

  // outputs are held at zero while reset is asserted, independent of the clock
  assign hit_any   = |hit;
  assign free_any  = |free;
  assign run_ok    = (state_q == e_run) & ~flush_i & ~reset_i;
  assign can_issue = run_ok & (credits_q != '0) & ~dcache_processing_miss_i;

  assign alloc_ready_and_o = run_ok & (hit_any | free_any);
  assign alloc_grant_o     = (alloc_v_i & alloc_ready_and_o & ~hit_any) ? (one_lp << free_id) : '0;

  assign v_o         = can_issue & (|gen_v_i);
  assign eff_addr_o  = v_o ? gen_eff_addr_i[grant_id*vaddr_width_p +: vaddr_width_p] : '0;
  assign stream_id_o = v_o ? grant_id : '0;
  assign issue       = v_o & yumi_i;
  assign gen_yumi_o  = issue ? (one_lp << grant_id) : '0;

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      e_run:   if (flush_i) state_d = e_drain;
      e_drain: if (!flush_i && credits_q == cw_lp'(credits_p)) state_d = e_run;
      default: state_d = e_run;
    endcase
    if (issue && !pfetch_commit_v_i)
      credits_d = credits_q - 1'b1;
    else if (pfetch_commit_v_i && !issue && credits_q != cw_lp'(credits_p))
      credits_d = credits_q + 1'b1;
    if (issue)
      rr_ptr_d = (grant_id == stream_id_width_lp'(num_streams_p-1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q   <= e_run;
      credits_q <= cw_lp'(credits_p);
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      rr_ptr_q  <= rr_ptr_d;
    end

endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// Directed bench for bp_be_prefetch_scheduler; issued prefetches are checked against a queue
// of expected {stream, address} pairs.

module tb_bp_be_prefetch_scheduler;
  localparam int W  = 39;
  localparam int N  = 4;
  localparam int SW = 2;

  logic             clk, rst, flush, alloc_v, alloc_ready;
  logic [W-1:0]     alloc_pc;
  logic [N-1:0]     alloc_grant, gen_idle, gen_v, gen_yumi;
  logic [N*W-1:0]   gen_eff_addr;
  logic             v_o, yumi, commit, miss;
  logic [W-1:0]     eff_addr;
  logic [SW-1:0]    stream_id;
  logic [W-1:0]     addr_tab [N];

  typedef struct { logic [SW-1:0] id; logic [W-1:0] addr; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  bp_be_prefetch_scheduler #(.vaddr_width_p(W), .num_streams_p(N), .credits_p(2)) dut
    (.clk_i(clk), .reset_i(rst), .flush_i(flush), .alloc_v_i(alloc_v), .alloc_pc_i(alloc_pc)
    ,.alloc_ready_and_o(alloc_ready), .alloc_grant_o(alloc_grant), .gen_idle_i(gen_idle)
    ,.gen_v_i(gen_v), .gen_eff_addr_i(gen_eff_addr), .gen_yumi_o(gen_yumi), .v_o(v_o)
    ,.eff_addr_o(eff_addr), .stream_id_o(stream_id), .yumi_i(yumi)
    ,.pfetch_commit_v_i(commit), .dcache_processing_miss_i(miss));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s);
    exp_t e;
    e.id   = SW'(s);
    e.addr = addr_tab[s];
    exp_q.push_back(e);
  endtask

  // settle, score any consumed prefetch, then advance one clock
  task automatic tick();
    exp_t e;
    #1;
    if (v_o && yumi) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 64'(stream_id), 64'hffff);
      else begin
        e = exp_q.pop_front();
        chk("sb_stream_id", 64'(stream_id), 64'(e.id));
        chk("sb_eff_addr", 64'(eff_addr), 64'(e.addr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      addr_tab[s] = W'(64'h4000_0000 + 64'(s) * 64'h100);
      gen_eff_addr[s*W +: W] = addr_tab[s];
    end
    rst = 1'b1; flush = 0; alloc_v = 1; alloc_pc = W'(64'h8000_1000); gen_idle = 4'b1111;
    gen_v = 4'b1111; yumi = 1; commit = 0; miss = 0;
    #3;
    chk("rst_v_o", 64'(v_o), 0);
    chk("rst_alloc_ready", 64'(alloc_ready), 0);
    chk("rst_alloc_grant", 64'(alloc_grant), 0);
    chk("rst_gen_yumi", 64'(gen_yumi), 0);
    chk("rst_eff_addr", 64'(eff_addr), 0);
    alloc_v = 0; gen_v = 0; yumi = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // allocation and dedup
    alloc_v = 1; alloc_pc = W'(64'h8000_1000); #1;
    chk("alloc0_ready", 64'(alloc_ready), 1);
    chk("alloc0_grant", 64'(alloc_grant), 4'b0001);
    tick(); gen_idle = 4'b1110; #1;
    chk("dedup_ready", 64'(alloc_ready), 1);
    chk("dedup_grant", 64'(alloc_grant), 0);
    tick(); alloc_pc = W'(64'h8000_1040); #1;
    chk("alloc1_grant", 64'(alloc_grant), 4'b0010);
    tick(); gen_idle = 4'b1100; alloc_pc = W'(64'h8000_1080); #1;
    chk("alloc2_grant", 64'(alloc_grant), 4'b0100);
    tick(); gen_idle = 4'b1000; alloc_pc = W'(64'h8000_10c0); #1;
    chk("alloc3_grant", 64'(alloc_grant), 4'b1000);
    tick(); gen_idle = 4'b0000; alloc_pc = W'(64'h8000_2000); #1;
    chk("full_ready", 64'(alloc_ready), 0);
    chk("full_grant", 64'(alloc_grant), 0);
    tick(); alloc_pc = W'(64'h8000_1040); #1;
    chk("full_dedup_ready", 64'(alloc_ready), 1);
    chk("full_dedup_grant", 64'(alloc_grant), 0);
    tick(); alloc_v = 0; gen_idle = 4'b0100;
    tick(); alloc_v = 1; alloc_pc = W'(64'h8000_2000); #1;
    chk("reuse_ready", 64'(alloc_ready), 1);
    chk("reuse_grant", 64'(alloc_grant), 4'b0100);
    tick(); alloc_v = 0; gen_idle = 4'b0000;

    // round robin with credits returned every cycle
    gen_v = 4'b1011; yumi = 1; commit = 1; #1;
    chk("rr_gen_yumi0", 64'(gen_yumi), 4'b0001);
    push(0); push(1); push(3); push(0); push(1);
    for (int i = 0; i < 5; i++) tick();
    chk("rr_drained", 64'(exp_q.size()), 0);
    gen_v = 0; yumi = 0; commit = 0;

    // credit exhaustion, simultaneous commit+issue, saturation
    gen_v = 4'b0001; yumi = 1; push(0); push(0);
    tick(); tick(); yumi = 0; #1;
    chk("cred_empty_v_o", 64'(v_o), 0);
    commit = 1; tick(); yumi = 1; #1;
    chk("cred_one_v_o", 64'(v_o), 1);
    push(0); tick(); commit = 0; #1;
    chk("cred_hold_v_o", 64'(v_o), 1);
    push(0); tick(); yumi = 0; #1;
    chk("cred_empty2_v_o", 64'(v_o), 0);
    gen_v = 0; commit = 1; tick(); tick(); tick();
    commit = 0; gen_v = 4'b0001; yumi = 1; push(0); push(0); #1;
    chk("sat_issue1", 64'(v_o), 1);
    tick(); #1;
    chk("sat_issue2", 64'(v_o), 1);
    tick(); yumi = 0; #1;
    chk("sat_empty_v_o", 64'(v_o), 0);
    commit = 1; tick(); tick(); commit = 0;

    // dcache miss gate
    miss = 1; #1;
    chk("miss_v_o", 64'(v_o), 0);
    chk("miss_gen_yumi", 64'(gen_yumi), 0);
    tick(); miss = 0; #1;
    chk("miss_release_v_o", 64'(v_o), 1);
    chk("miss_release_id", 64'(stream_id), 0);
    push(0); yumi = 1; tick(); yumi = 0;

    // flush with one credit outstanding
    flush = 1; alloc_v = 1; alloc_pc = W'(64'h8000_1000); gen_idle = 4'b1111; #1;
    chk("flush_v_o", 64'(v_o), 0);
    chk("flush_alloc_ready", 64'(alloc_ready), 0);
    chk("flush_alloc_grant", 64'(alloc_grant), 0);
    tick(); flush = 0; #1;
    chk("drain_v_o", 64'(v_o), 0);
    chk("drain_alloc_ready", 64'(alloc_ready), 0);
    tick(); commit = 1; tick(); commit = 0; tick(); #1;
    chk("drain_exit_v_o", 64'(v_o), 1);
    chk("table_cleared_grant", 64'(alloc_grant), 4'b0001);
    alloc_v = 0;

    // asynchronous reset while draining
    flush = 1; tick(); flush = 0; #1;
    chk("drain2_v_o", 64'(v_o), 0);
    rst = 1; #1;
    chk("async_rst_v_o", 64'(v_o), 0);
    chk("async_rst_ready", 64'(alloc_ready), 0);
    rst = 0; #1;
    chk("post_rst_v_o", 64'(v_o), 1);
    chk("post_rst_ready", 64'(alloc_ready), 1);
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
